// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Receives a boot image over the UART RX pin (8N1, LSB first) and writes it
//   byte-by-byte into Memory. Frame on the wire: 0x55, len_lo, len_hi,
//   len payload bytes, then an 8-bit wrapping sum of the payload.
//   Optional build feature: define UART_BOOT_LOADER_TIMEOUT_EN to abort a
//   frame that stays idle for TIMEOUT_CYCLES (err_code 5).
//
//   Memory handshake: mem_req rises with mem_addr/mem_data stable and holds
//   until the cycle in which mem_done is sampled high; it drops on the next
//   edge, so there is always at least one idle cycle between requests.
//   mem_done is ignored while mem_req is low. mem_write mirrors mem_req.
//
//   core_reset is the reset for the core downstream: held until the image is
//   loaded and verified. dbg_state exposes the frame state machine.
module uart_boot_loader #(
    parameter int          CLK_FREQ       = 27000000,
    parameter int          BAUD           = 115200,
    parameter logic [15:0] MAX_SIZE       = 16'hf000,
    parameter int          TIMEOUT_CYCLES = 27000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic        mem_req,
    input  logic        mem_done,
    output logic        busy,
    output logic        load_done,
    output logic        load_error,
    output logic [2:0]  err_code,
    output logic        core_reset,
    output logic [2:0]  dbg_state
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [15:0] CPB_M1       = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1      = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;

    // ---------------- RX synchroniser ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // Reset to 1 so a released reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- RX deserialiser ----------------
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_push, rx_frame_err;

    // RX state and bit-timing registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: half-bit start check, then mid-bit samples of data and stop.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q && rx_prev_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A line already high again is a glitch, not a start bit.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CPB_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CPB_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: one-cycle byte strobe or framing error at the stop sample.
    always_comb begin
        rx_push      = 1'b0;
        rx_frame_err = 1'b0;
        if (rx_state_q == RX_STOP && rx_cnt_q == CPB_M1) begin
            rx_push      = rx_sync_q;
            rx_frame_err = !rx_sync_q;
        end
    end

    // ---------------- 4-entry byte FIFO ----------------
    logic [7:0] fifo_mem_q [4];
    logic [7:0] fifo_mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       fifo_empty, fifo_full, fifo_pop, fifo_push, fifo_ovf;
    logic [7:0] fifo_byte;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign fifo_byte  = fifo_mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign fifo_push  = rx_push && (!fifo_full || fifo_pop);
    assign fifo_ovf   = rx_push && fifo_full && !fifo_pop;

    // FIFO pointer, occupancy and storage updates.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (fifo_pop) rd_ptr_d = rd_ptr_q + 2'd1;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ---------------- Optional idle timeout ----------------
    logic timeout_hit;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;

    // Idle counter: cleared by every received byte, runs only inside a frame.
    always_comb begin
        to_cnt_d = '0;
        if (busy && !rx_push) to_cnt_d = to_cnt_q + 32'd1;
    end

    // Timeout counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    // Fires only once no write is outstanding, so a pending request completes.
    assign timeout_hit = busy && !mem_req_q && (to_cnt_q >= 32'(TIMEOUT_CYCLES));
`else
    // No timer in this build: the expression is constant false.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // ---------------- Frame FSM and write sequencer ----------------
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d, addr_q, addr_d;
    logic [7:0]  sum_q, sum_d;
    logic [2:0]  err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        terminal, abort, wr_issue, wr_complete;

    assign terminal    = (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign abort       = !terminal && (rx_frame_err || fifo_ovf || timeout_hit);
    assign wr_complete = mem_req_q && mem_done;

    // Frame FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Frame FSM next state; the first error seen is the one recorded.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        err_d   = err_q;
        if (abort) begin
            state_d = ST_ERROR;
            err_d   = rx_frame_err ? 3'd1 : (fifo_ovf ? 3'd2 : 3'd5);
        end else begin
            case (state_q)
                ST_IDLE: if (fifo_pop && fifo_byte == 8'h55) state_d = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (fifo_pop) begin
                        len_d[7:0] = fifo_byte;
                        state_d    = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (fifo_pop) begin
                        len_d  = {fifo_byte, len_q[7:0]};
                        addr_d = '0;
                        sum_d  = '0;
                        if ({fifo_byte, len_q[7:0]} > MAX_SIZE) begin
                            state_d = ST_ERROR;
                            err_d   = 3'd3;
                        end else if ({fifo_byte, len_q[7:0]} == 16'd0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (wr_complete) begin
                        addr_d = addr_q + 16'd1;
                        sum_d  = sum_q + mem_data_q;
                        if (addr_q == len_q - 16'd1) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (fifo_pop) begin
                        if (fifo_byte == sum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = 3'd4;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Frame FSM outputs: status flags, FIFO pop and write issue.
    always_comb begin
        busy       = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;
        wr_issue   = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_LEN_LO, ST_LEN_HI, ST_CHECK: begin
                busy     = 1'b1;
                fifo_pop = !fifo_empty;
            end
            ST_PAYLOAD: begin
                busy     = 1'b1;
                // Payload bytes leave the FIFO only when the sequencer is idle.
                wr_issue = !fifo_empty && !mem_req_q && !rx_frame_err && !timeout_hit;
                fifo_pop = wr_issue;
            end
            ST_DONE: begin
                load_done = 1'b1;
                fifo_pop  = !fifo_empty;
            end
            ST_ERROR: begin
                load_error = 1'b1;
                fifo_pop   = !fifo_empty;
            end
            default: fifo_pop = !fifo_empty;
        endcase
    end

    // Write sequencer: launch a request, hold it until mem_done, then release.
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (mem_req_q) begin
            if (mem_done) mem_req_d = 1'b0;
        end else if (wr_issue) begin
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = fifo_byte;
        end
    end

    // Frame datapath and write sequencer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            err_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            len_q      <= len_d;
            addr_q     <= addr_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_write  = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign err_code   = err_q;
    assign core_reset = reset | ~load_done;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: 16 clocks per UART bit, behavioural Memory
// responder, and a frame-level reference model that derives the expected
// write list and final status directly from the byte stream.
module tb_uart_boot_loader;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_done = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write, mem_req, busy, load_done, load_error, core_reset;
    logic [2:0]  err_code, dbg_state;

    uart_boot_loader #(
        .CLK_FREQ(1600000),
        .BAUD(100000)
    ) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mem_req(mem_req), .mem_done(mem_done), .busy(busy),
        .load_done(load_done), .load_error(load_error), .err_code(err_code),
        .core_reset(core_reset), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    int          mem_delay = 1;
    int          mem_cnt = 0;
    int          req_cycles = 0;
    int          qual_bad = 0;
    logic [23:0] wr_log[$];
    logic [23:0] exp_q[$];
    logic        exp_done, exp_err;
    logic [2:0]  exp_code;
    logic [7:0]  frame[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Memory responder ----------------
    // Raises mem_done mem_delay cycles after a request appears, logs the write.
    always @(negedge clock) begin
        if (mem_write !== mem_req) qual_bad++;
        if (mem_req) req_cycles++;
        if (!mem_req || mem_done) begin
            mem_done = 1'b0;
            mem_cnt  = 0;
        end else begin
            mem_cnt++;
            if (mem_cnt >= mem_delay) begin
                mem_done = 1'b1;
                wr_log.push_back({mem_addr, mem_data});
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_run(input logic [7:0] b[$]);
        int          i;
        logic [15:0] len;
        logic [7:0]  sum;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_code = 3'd0;
        i = 0;
        while (i < b.size() && b[i] != 8'h55) i++;
        if (i + 2 >= b.size()) return;
        len = {b[i+2], b[i+1]};
        i += 3;
        if (len > 16'hf000) begin
            exp_err  = 1'b1;
            exp_code = 3'd3;
            return;
        end
        sum = 8'h00;
        for (int k = 0; k < int'(len); k++) begin
            exp_q.push_back({16'(k), b[i+k]});
            sum += b[i+k];
        end
        i += int'(len);
        if (b[i] == sum) exp_done = 1'b1;
        else begin
            exp_err  = 1'b1;
            exp_code = 3'd4;
        end
    endfunction

    function automatic void build(input logic [7:0] pre[$], input logic [7:0] pay[$],
                                  input logic corrupt);
        logic [7:0] s;
        s = 8'h00;
        frame = pre;
        frame.push_back(8'h55);
        frame.push_back(8'(pay.size()));
        frame.push_back(8'(pay.size() >> 8));
        foreach (pay[i]) begin
            frame.push_back(pay[i]);
            s += pay[i];
        end
        frame.push_back(corrupt ? (s ^ 8'h01) : s);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        wr_log.delete();
        req_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clock);
        #1;
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (CPB) @(posedge clock);
            #1;
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clock);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        foreach (b[i]) send_byte(b[i], 1'b1);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(load_done || load_error) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        #1;
        check("end_in_time", 32'(n < 3000), 32'd1);
    endtask

    task automatic compare_model(input string tag);
        int n;
        check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
        n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(wr_log[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(load_done), 32'(exp_done));
        check({tag, "_err"}, 32'(load_error), 32'(exp_err));
        check({tag, "_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_core_rst"}, 32'(core_reset), 32'(!exp_done));
        if (exp_q.size() == 0) check({tag, "_no_req"}, 32'(req_cycles), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] pre[$];
        logic [7:0] pay[$];
        logic [7:0] b;
        int         n;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_core_rst", 32'(core_reset), 32'd1);
        do_reset();

        // Basic three-byte image
        mem_delay = 1;
        frame = '{8'h55, 8'h03, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'h31};
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("t1");
        check("t1_done_const", 32'(load_done), 32'd1);

        // Leading garbage, zero-length image
        do_reset();
        frame = '{8'h12, 8'h34, 8'h55, 8'h00, 8'h00, 8'h00};
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("t2");

        // Bad checksum
        do_reset();
        frame = '{8'h55, 8'h01, 8'h00, 8'h10, 8'h11};
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("t3");
        check("t3_code_const", 32'(err_code), 32'd4);

        // Length one above the limit
        do_reset();
        frame = '{8'h55, 8'h01, 8'hf0};
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("t4");
        check("t4_no_req", 32'(req_cycles), 32'd0);

        // FIFO overflow behind a very slow write
        do_reset();
        mem_delay = 2000;
        pre.delete();
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        build(pre, pay, 1'b0);
        send_frame(frame);
        wait_end();
        check("ovf_err", 32'(load_error), 32'd1);
        check("ovf_code", 32'(err_code), 32'd2);
        check("ovf_done", 32'(load_done), 32'd0);

        // Same frame, memory fast enough for the FIFO to absorb it
        do_reset();
        mem_delay = 20;
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("slow20");

        // Framing error, then later traffic must not replace the first code
        do_reset();
        mem_delay = 1;
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("frm_code", 32'(err_code), 32'd1);
        check("frm_err", 32'(load_error), 32'd1);
        frame = '{8'h55, 8'h01, 8'hf0};
        send_frame(frame);
        repeat (4) @(posedge clock);
        #1;
        check("frm_first_wins", 32'(err_code), 32'd1);

        // Reset during the second payload write
        do_reset();
        mem_delay = 20;
        pay = '{8'h21, 8'h43, 8'h65, 8'h87};
        build(pre, pay, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b1);
        n = 0;
        while (!(mem_req && mem_addr == 16'd1 && wr_log.size() == 1) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("mid_2nd_write_seen", 32'(n < 300), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_write", 32'(mem_write), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_data", 32'(mem_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_status", 32'({load_done, load_error, err_code}), 32'd0);
        do_reset();
        model_run(frame);
        send_frame(frame);
        wait_end();
        compare_model("reload");

        // Randomized frames
        for (int t = 0; t < 4; t++) begin
            do_reset();
            mem_delay = $urandom_range(1, 20);
            pre.delete();
            pay.delete();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h54;
                pre.push_back(b);
            end
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(16'hf001, 16'hffff);
                frame = pre;
                frame.push_back(8'h55);
                frame.push_back(8'(n));
                frame.push_back(8'(n >> 8));
            end else begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
                build(pre, pay, ($urandom_range(0, 3) == 0));
            end
            model_run(frame);
            send_frame(frame);
            wait_end();
            compare_model("rnd");
        end

        check("mem_write_qual", 32'(qual_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
